// File: rtl/up_down_counter_ctrl.sv
// Round-robin command sequencer for a shared 4-bit up/down counter: steps the counter to a granted target, then pulses done.
// Optional MOD_SHORTEST_EN: choose the shorter modular direction and let the counter wrap.
module up_down_counter_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear_b,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_target,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_target,
  output logic             req1_ready,
  input  logic             pause,
  input  logic [WIDTH-1:0] count,
  output logic             up,
  output logic             down,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] target_q;
  logic             dir_up_q;
  logic             owner_q;
  logic             last_grant_q;

  logic             grant_valid;
  logic             grant_id;
  logic [WIDTH-1:0] grant_target;
  logic             accept;
  logic             at_target;

  function automatic logic pick_up(input logic [WIDTH-1:0] tgt, input logic [WIDTH-1:0] cur);
`ifdef MOD_SHORTEST_EN
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] half;
    half = {1'b1, {(WIDTH-1){1'b0}}};
    diff = tgt - cur;
    // A half-way tie resolves upward
    return (diff != '0) && (diff <= half);
`else
    return tgt > cur;
`endif
  endfunction

  always_comb begin
    grant_valid = req0_valid | req1_valid;
    grant_id    = 1'b0;
    if (req0_valid && req1_valid) grant_id = ~last_grant_q;
    else                          grant_id = req1_valid;
  end

  assign grant_target = grant_id ? req1_target : req0_target;
  assign accept       = (state == IDLE) && grant_valid;
  assign req0_ready   = accept & ~grant_id;
  assign req1_ready   = accept & grant_id;
  assign at_target    = (count == target_q);

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) state <= IDLE;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b) begin
      target_q     <= '0;
      dir_up_q     <= 1'b0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else if (accept) begin
      target_q     <= grant_target;
      dir_up_q     <= pick_up(grant_target, count);
      owner_q      <= grant_id;
      last_grant_q <= grant_id;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (grant_valid) state_next = RUN;
      RUN:     if (at_target)   state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes depend only on registered state and the registered counter value
  always_comb begin
    up      = 1'b0;
    down    = 1'b0;
    busy    = (state != IDLE);
    done    = 1'b0;
    done_id = 1'b0;
    if (state == RUN && !pause && !at_target) begin
      up   = dir_up_q;
      down = ~dir_up_q;
    end
    if (state == DONE) begin
      done    = 1'b1;
      done_id = owner_q;
    end
  end

endmodule

// File: tb/tb_up_down_counter_ctrl.sv
// Directed bench for up_down_counter_ctrl with a behavioural 4-bit counter closing the loop on count.
module tb_up_down_counter_ctrl;

  logic       clk = 1'b0;
  logic       clear_b;
  logic       req0_valid, req1_valid;
  logic [3:0] req0_target, req1_target;
  logic       req0_ready, req1_ready;
  logic       pause;
  logic [3:0] count;
  logic       up, down, busy, done, done_id;
  logic       load_en;
  logic [3:0] load_val;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [3:0] start;
    logic       v0;
    logic [3:0] t0;
    logic       v1;
    logic [3:0] t1;
    int         pstart;
    int         plen;
    logic       exp_id;
    int         exp_up;
    int         exp_down;
    int         exp_done;
  } vec_t;

  vec_t vecs[9];

  up_down_counter_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .clear_b(clear_b),
    .req0_valid(req0_valid), .req0_target(req0_target), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_target(req1_target), .req1_ready(req1_ready),
    .pause(pause), .count(count),
    .up(up), .down(down), .busy(busy), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared up_down_counter_4bit, with a preload hook for the bench
  always_ff @(posedge clk or negedge clear_b) begin
    if (!clear_b)     count <= 4'd0;
    else if (load_en) count <= load_val;
    else if (up)      count <= count + 4'd1;
    else if (down)    count <= count - 4'd1;
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int ups, downs, both, dcyc, did, k;
    @(negedge clk);
    load_en  = 1'b1;
    load_val = v.start;
    @(negedge clk);
    load_en     = 1'b0;
    req0_valid  = v.v0;
    req0_target = v.t0;
    req1_valid  = v.v1;
    req1_target = v.t1;
    #1;
    check($sformatf("v%0d_ready0", idx), int'(req0_ready), int'(v.exp_id == 1'b0));
    check($sformatf("v%0d_ready1", idx), int'(req1_ready), int'(v.exp_id == 1'b1));
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    ups = 0; downs = 0; both = 0; dcyc = 0; did = -1;
    for (k = 1; k <= 60 && dcyc == 0; k++) begin
      @(negedge clk);
      pause = (k >= v.pstart) && (k < v.pstart + v.plen);
      #1;
      if (up) ups++;
      if (down) downs++;
      if (up && down) both++;
      if (done) begin
        dcyc = k;
        did  = int'(done_id);
      end
    end
    pause = 1'b0;
    check($sformatf("v%0d_ups", idx), ups, v.exp_up);
    check($sformatf("v%0d_downs", idx), downs, v.exp_down);
    check($sformatf("v%0d_overlap", idx), both, 0);
    check($sformatf("v%0d_done_cycle", idx), dcyc, v.exp_done);
    check($sformatf("v%0d_done_id", idx), did, int'(v.exp_id));
    check($sformatf("v%0d_final_count", idx), int'(count), int'(v.exp_id ? v.t1 : v.t0));
  endtask

  initial begin
    int g, cyc, seen, found;
    int gid[3];
    int gcyc[3];

    // start, v0, t0, v1, t1, pause_start, pause_len, id, ups, downs, done_cycle
    vecs[0] = '{4'd0,  1'b1, 4'd5,  1'b0, 4'd0,  0, 0, 1'b0, 5, 0, 7};
    vecs[1] = '{4'd9,  1'b0, 4'd0,  1'b1, 4'd3,  0, 0, 1'b1, 0, 6, 8};
    vecs[2] = '{4'd7,  1'b1, 4'd7,  1'b0, 4'd0,  0, 0, 1'b0, 0, 0, 2};
    vecs[3] = '{4'd0,  1'b1, 4'd6,  1'b0, 4'd0,  3, 2, 1'b0, 6, 0, 10};
    vecs[4] = '{4'd3,  1'b1, 4'd11, 1'b0, 4'd0,  0, 0, 1'b0, 8, 0, 10};
`ifdef MOD_SHORTEST_EN
    vecs[5] = '{4'd14, 1'b1, 4'd1,  1'b0, 4'd0,  0, 0, 1'b0, 3, 0, 5};
    vecs[6] = '{4'd15, 1'b0, 4'd0,  1'b1, 4'd0,  0, 0, 1'b1, 1, 0, 3};
    vecs[7] = '{4'd0,  1'b0, 4'd0,  1'b1, 4'd15, 0, 0, 1'b1, 0, 1, 3};
    vecs[8] = '{4'd11, 1'b0, 4'd0,  1'b1, 4'd3,  0, 0, 1'b1, 8, 0, 10};
`else
    vecs[5] = '{4'd14, 1'b1, 4'd1,  1'b0, 4'd0,  0, 0, 1'b0, 0, 13, 15};
    vecs[6] = '{4'd15, 1'b0, 4'd0,  1'b1, 4'd0,  0, 0, 1'b1, 0, 15, 17};
    vecs[7] = '{4'd0,  1'b0, 4'd0,  1'b1, 4'd15, 0, 0, 1'b1, 15, 0, 17};
    vecs[8] = '{4'd11, 1'b0, 4'd0,  1'b1, 4'd3,  0, 0, 1'b1, 0, 8, 10};
`endif

    clear_b = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    req0_target = 4'd0; req1_target = 4'd0; pause = 1'b0;
    load_en = 1'b0; load_val = 4'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_up_down", int'({up, down}), 0);
    clear_b = 1'b1;
    @(negedge clk);
    #1;
    check("rst_done", int'({done, done_id}), 0);
    check("rst_ready", int'({req0_ready, req1_ready}), 0);
    check("rst_count", int'(count), 0);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

    // Reset while stepping up from 0 toward 5
    @(negedge clk);
    load_en = 1'b1; load_val = 4'd0;
    @(negedge clk);
    load_en = 1'b0; req0_valid = 1'b1; req0_target = 4'd5;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      #1;
      if (count == 4'd3) found = 1;
    end
    check("clr_reached3", found, 1);
    check("clr_busy_before", int'(busy), 1);
    clear_b = 1'b0;
    #1;
    check("clr_up_down", int'({up, down}), 0);
    check("clr_busy", int'(busy), 0);
    check("clr_count", int'(count), 0);
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      #1;
      if (done) seen++;
    end
    clear_b = 1'b1;
    @(negedge clk);
    #1;
    if (done) seen++;
    check("clr_no_done", seen, 0);
    check("clr_idle", int'(busy), 0);
    check("clr_count_after", int'(count), 0);

    // Continuous tie: grants must alternate starting with req0 after reset
    req0_valid = 1'b1; req0_target = 4'd2;
    req1_valid = 1'b1; req1_target = 4'd4;
    g = 0; cyc = 0; seen = 0;
    while (cyc < 60 && g < 3) begin
      #1;
      if (req0_ready && req1_ready) seen++;
      if (req0_ready || req1_ready) begin
        gid[g]  = int'(req1_ready);
        gcyc[g] = cyc;
        g++;
      end
      if (g == 3) begin
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    check("tie_grants", g, 3);
    check("tie_both_ready", seen, 0);
    if (g == 3) begin
      check("tie_g0", gid[0], 0);
      check("tie_g1", gid[1], 1);
      check("tie_g2", gid[2], 0);
      check("tie_gap01", gcyc[1] - gcyc[0], 5);
      check("tie_gap12", gcyc[2] - gcyc[1], 5);
    end
    found = 0;
    for (int k = 0; k < 20 && found == 0; k++) begin
      @(negedge clk);
      #1;
      if (done) begin
        found = 1;
        check("tie_last_done_id", int'(done_id), 0);
      end
    end
    check("tie_last_done", found, 1);
    check("tie_last_count", int'(count), 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/up_down_counter_ctrl.md
# up_down_counter_ctrl

Sequencing controller for the 4-bit up/down counter. It accepts move-to-target commands from two requesters through valid/ready handshakes and arbitrates between them round-robin. It then drives the counter's `up`/`down` strobes one step per clock until the counter output equals the granted target, and reports completion. It sits between the two command sources and a single shared `up_down_counter_4bit` instance, whose `A` output it monitors.

## Interface
- `WIDTH`, 4, counter and target width in bits.
- `clk`  input  1  rising-edge clock, shared with the counter.
- `clear_b`  input  1  asynchronous active-low reset; connect to the counter's `clear_b` as well.
- `req0_valid`  input  1  requester 0 command valid.
- `req0_target`  input  WIDTH  requester 0 target count.
- `req0_ready`  output  1  requester 0 command accepted this cycle.
- `req1_valid`  input  1  requester 1 command valid.
- `req1_target`  input  WIDTH  requester 1 target count.
- `req1_ready`  output  1  requester 1 command accepted this cycle.
- `pause`  input  1  freeze stepping while in RUN.
- `count`  input  WIDTH  counter output `A`.
- `up`  output  1  count-up strobe to the counter.
- `down`  output  1  count-down strobe to the counter.
- `busy`  output  1  a command is in progress (RUN or DONE).
- `done`  output  1  one-cycle completion pulse.
- `done_id`  output  1  requester whose command completed; valid while `done`=1.

## Operation
- States: IDLE, RUN, DONE.
- Registers: `target_q`, `dir_up_q`, `owner_q`, `last_grant_q`.
- Reset values:
  - state=IDLE, `target_q`=0, `dir_up_q`=0, `owner_q`=0, `last_grant_q`=1.
  - All outputs 0, with `up`=`down`=0 immediately on `clear_b` low.
- IDLE:
  - If exactly one `reqN_valid`=1, grant it.
  - If both are valid, grant the requester other than `last_grant_q`, so req0 wins the first tie after reset.
  - `reqN_ready` is combinational and asserted only for the granted requester. Handshake = valid & ready.
  - On handshake: latch target and owner, update `last_grant_q`, compute direction, go to RUN.
  - With no valid request, stay in IDLE.
- Direction, computed at accept against the current `count`:
  - Without the macro: up if target > count, else down.
- RUN:
  - `up` = `dir_up_q` & ~pause & (count != target_q).
  - `down` = ~`dir_up_q` & ~pause & (count != target_q).
  - `up` and `down` are never both 1.
  - When count == target_q: no strobe; go to DONE.
  - `pause` holds the state and suppresses strobes; equality is still checked while paused.
- DONE:
  - `done`=1 and `done_id`=`owner_q` for one cycle, then return to IDLE.
  - No grant is issued in DONE.
- `busy` = (state != IDLE).
- Requesters must hold valid and target stable until ready; the controller does not enforce this.
- Reset mid-operation aborts the command without a `done` pulse. Counter and controller both clear to 0.

## Timing
- `up`/`down` are combinational from registered state and the registered `count`; there is no combinational loop.
- Distance d = number of counter steps to the target.
  - Handshake in cycle 0.
  - Strobes in cycles 1..d; `count` updates at the edge ending each strobe cycle.
  - Equality is detected in cycle d+1.
  - `done` is asserted in cycle d+2.
  - The next grant is possible in cycle d+3.
- Target equal to count at accept: RUN for 1 cycle, `done` in cycle 2.
- Each pause cycle adds one cycle of latency.
- The wrap-around step 15→0 (up) or 0→15 (down) occurs only when `MOD_SHORTEST_EN` is defined.

## Configuration
- `MOD_SHORTEST_EN` defined:
  - Direction takes the shorter modular path: diff = (target − count) mod 2^WIDTH.
  - Up if 0 < diff ≤ 2^(WIDTH−1) (a tie of 8 goes up), else down. The counter wraps.
- `MOD_SHORTEST_EN` undefined:
  - Plain magnitude compare, never wraps.
  - d = |target − count|.

## Test plan
- Reset, then count=0, req0 target=5:
  - `req0_ready` in cycle 0.
  - `up`=1 in cycles 1–5; count reaches 5.
  - `done`=1, `done_id`=0 in cycle 7.
- Count=9, req1 target=3 (macro off):
  - `down` for 6 cycles; `done_id`=1 at cycle 8.
  - No `up` pulse at any point.
- Both requests valid simultaneously, repeatedly, targets 2 and 4:
  - Grants alternate req0, req1, req0.
  - A losing valid held through RUN/DONE is granted in the next IDLE.
- Count=14, target=1:
  - Macro on: `up` for 3 cycles, count goes 15, 0, 1.
  - Macro off: `down` for 13 cycles.
- Target 6 from 0 with `pause`=1 for 2 cycles mid-RUN:
  - 6 `up` strobes total; `done` at cycle 10.
- `clear_b` low in RUN at count=3:
  - `up`/`down`/`busy` go to 0 immediately; no `done`.
  - After release, IDLE with count=0 and req0 has priority.
